// File: rtl/systolic_mac_array_if.sv
// Operand, control and result bundle between the input stage,
// the systolic MAC array and the output serializer.
interface systolic_mac_array_if #(
  parameter int D_W   = 8,
  parameter int N     = 2,
  parameter int ACC_W = 20
);
  localparam int RW = $clog2(N*N+1);

  logic [N*D_W-1:0]     in_x_flat;
  logic [N*D_W-1:0]     in_y_flat;
  logic                 init;
  logic                 busy;
  logic                 result_valid;
  logic [N*N*ACC_W-1:0] result_flat;
  logic [RW-1:0]        rd_idx;
  logic [ACC_W-1:0]     rd_data;

  modport master (
    output in_x_flat, in_y_flat, init, rd_idx,
    input  busy, result_valid, result_flat, rd_data
  );

  modport slave (
    input  in_x_flat, in_y_flat, init, rd_idx,
    output busy, result_valid, result_flat, rd_data
  );
endinterface

// File: rtl/systolic_mac_array.sv
// Output-stationary N x N systolic MAC array with a fixed
// compute window and a registered indexed result read port.
module systolic_mac_array #(
  parameter int D_W            = 8,
  parameter int N              = 2,
  parameter int ACC_W          = 20,
  parameter int COMPUTE_CYCLES = 3*N+2
) (
  input logic                 clk,
  input logic                 rst,
  systolic_mac_array_if.slave bus
);
  localparam int RW = $clog2(N*N+1);
  localparam int CW = $clog2(COMPUTE_CYCLES+1);
  localparam int PW = 2*D_W;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  state_t state, state_nx;
  logic   clr;
  logic   acc_en;
  logic   last;

  logic [CW-1:0] cnt;

  logic signed [D_W-1:0]   x_reg [N][N];
  logic signed [D_W-1:0]   y_reg [N][N];
  logic signed [D_W-1:0]   x_in  [N][N];
  logic signed [D_W-1:0]   y_in  [N][N];
  logic signed [PW-1:0]    prod  [N][N];
  logic signed [ACC_W-1:0] acc   [N*N];
  logic [ACC_W-1:0]        rd_sel;

  assign last = (cnt == CW'(COMPUTE_CYCLES-1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // init always restarts a clean window, whatever the state
  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    acc_en   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.init) begin
          state_nx = COMPUTE;
          clr      = 1'b1;
        end
      end
      COMPUTE: begin
        if (bus.init) begin
          clr = 1'b1;
        end else begin
          acc_en = 1'b1;
          if (last) state_nx = DONE;
        end
      end
      DONE: begin
        if (bus.init) begin
          state_nx = COMPUTE;
          clr      = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.busy         = (state == COMPUTE);
  assign bus.result_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (acc_en) cnt <= cnt + CW'(1);
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      x_in[i][0] = bus.in_x_flat[i*D_W +: D_W];
      y_in[0][i] = bus.in_y_flat[i*D_W +: D_W];
      for (int j = 1; j < N; j++) begin
        x_in[i][j] = x_reg[i][j-1];
        y_in[j][i] = y_reg[j-1][i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        prod[i][j] = PW'(x_in[i][j]) * PW'(y_in[i][j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (rst || clr) begin
          x_reg[i][j] <= '0;
          y_reg[i][j] <= '0;
          acc[i*N+j]  <= '0;
        end else begin
          x_reg[i][j] <= x_in[i][j];
          y_reg[i][j] <= y_in[i][j];
          if (acc_en)
            acc[i*N+j] <= acc[i*N+j] + ACC_W'(prod[i][j]);
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N*N; k++) begin
      bus.result_flat[k*ACC_W +: ACC_W] = acc[k];
    end
  end

  // out-of-range indices fall through to zero
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < N*N; k++) begin
      if (bus.rd_idx == RW'(k)) rd_sel = acc[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) bus.rd_data <= '0;
    else     bus.rd_data <= rd_sel;
  end
endmodule

// File: tb/tb_systolic_mac_array.sv
// Randomized bench for systolic_mac_array against a plain
// matrix-product model, with a 16-bit accumulator twin for wrap.
module tb_systolic_mac_array;
  localparam int D_W = 8;
  localparam int N   = 2;
  localparam int AW  = 20;
  localparam int AW2 = 16;
  localparam int CC  = 3*N+2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  systolic_mac_array_if #(.D_W(D_W), .N(N), .ACC_W(AW))  bus ();
  systolic_mac_array_if #(.D_W(D_W), .N(N), .ACC_W(AW2)) bus_w ();

  assign bus_w.in_x_flat = bus.in_x_flat;
  assign bus_w.in_y_flat = bus.in_y_flat;
  assign bus_w.init      = bus.init;
  assign bus_w.rd_idx    = bus.rd_idx;

  systolic_mac_array #(
    .D_W(D_W), .N(N), .ACC_W(AW), .COMPUTE_CYCLES(CC)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  systolic_mac_array #(
    .D_W(D_W), .N(N), .ACC_W(AW2), .COMPUTE_CYCLES(CC)
  ) u_wrap (
    .clk(clk),
    .rst(rst),
    .bus(bus_w)
  );

  int checks = 0;
  int failures = 0;

  int xm [N][N];
  int ym [N][N];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // C = X * Y, reduced to w bits
  function automatic logic [63:0] ref_acc(int i, int j, int w);
    longint s;
    s = 0;
    for (int k = 0; k < N; k++) s += longint'(xm[i][k] * ym[k][j]);
    return 64'(s & ((longint'(1) << w) - 1));
  endfunction

  function automatic int rnd_op();
    logic signed [D_W-1:0] b;
    b = D_W'($urandom);
    return int'(b);
  endfunction

  task automatic rand_lanes();
    bus.in_x_flat = (N*D_W)'($urandom);
    bus.in_y_flat = (N*D_W)'($urandom);
  endtask

  task automatic zero_lanes();
    bus.in_x_flat = '0;
    bus.in_y_flat = '0;
  endtask

  // lane r carries element k-r of its row/column (upstream skew)
  task automatic set_lanes(input int k);
    int idx;
    int xv;
    int yv;
    for (int r = 0; r < N; r++) begin
      idx = k - r;
      xv = 0;
      yv = 0;
      if (idx >= 0 && idx < N) begin
        xv = xm[r][idx];
        yv = ym[idx][r];
      end
      bus.in_x_flat[r*D_W +: D_W] = D_W'(xv);
      bus.in_y_flat[r*D_W +: D_W] = D_W'(yv);
    end
  endtask

  task automatic do_run();
    @(negedge clk);
    bus.init = 1'b1;
    rand_lanes();
    @(negedge clk);
    bus.init = 1'b0;
    chk("clr_flat", 64'(bus.result_flat), 64'd0);
    chk("clr_valid", 64'(bus.result_valid), 64'd0);
    for (int k = 0; k < CC; k++) begin
      chk("busy", 64'(bus.busy), 64'd1);
      if (k == CC-1)
        chk("early_valid", 64'(bus.result_valid), 64'd0);
      set_lanes(k);
      @(negedge clk);
    end
    zero_lanes();
    chk("valid", 64'(bus.result_valid), 64'd1);
    chk("busy_off", 64'(bus.busy), 64'd0);
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        chk({tag, "_a20"},
            64'(bus.result_flat[(i*N+j)*AW +: AW]),
            ref_acc(i, j, AW));
        chk({tag, "_a16"},
            64'(bus_w.result_flat[(i*N+j)*AW2 +: AW2]),
            ref_acc(i, j, AW2));
      end
    end
  endtask

  task automatic read_sweep();
    logic [63:0] exp;
    for (int idx = 0; idx <= N*N; idx++) begin
      bus.rd_idx = ($clog2(N*N+1))'(idx);
      rand_lanes();
      @(negedge clk);
      exp = (idx < N*N) ? ref_acc(idx / N, idx % N, AW) : 64'd0;
      chk("rd_data", 64'(bus.rd_data), exp);
    end
    zero_lanes();
    chk("frozen_valid", 64'(bus.result_valid), 64'd1);
    check_results("frozen");
  endtask

  initial begin
    bus.init = 1'b0;
    bus.rd_idx = '0;
    rand_lanes();

    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rand_lanes();
      bus.init = 1'($urandom);
    end
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_valid", 64'(bus.result_valid), 64'd0);
    chk("rst_flat", 64'(bus.result_flat), 64'd0);
    chk("rst_rd", 64'(bus.rd_data), 64'd0);
    chk("rst_flat16", 64'(bus_w.result_flat), 64'd0);
    bus.init = 1'b0;
    rst = 1'b0;
    zero_lanes();
    @(negedge clk);
    chk("idle_busy", 64'(bus.busy), 64'd0);

    xm = '{'{1, 2}, '{3, 4}};
    ym = '{'{5, 7}, '{6, 8}};
    do_run();
    chk("mm_pe00", 64'(bus.result_flat[0*AW +: AW]), 64'd17);
    chk("mm_pe01", 64'(bus.result_flat[1*AW +: AW]), 64'd23);
    chk("mm_pe10", 64'(bus.result_flat[2*AW +: AW]), 64'd39);
    chk("mm_pe11", 64'(bus.result_flat[3*AW +: AW]), 64'd53);
    read_sweep();

    xm = '{'{-1, 2}, '{0, 0}};
    ym = '{'{3, 0}, '{-4, 0}};
    do_run();
    chk("sgn_pe00", 64'(bus.result_flat[0 +: AW]), 64'h0FFFF5);
    check_results("signed");

    xm = '{'{-128, -128}, '{-128, -128}};
    ym = '{'{-128, -128}, '{-128, -128}};
    do_run();
    chk("wrap16", 64'(bus_w.result_flat[0 +: AW2]), 64'h8000);
    chk("wrap20", 64'(bus.result_flat[0 +: AW]), 64'h08000);
    check_results("wrap");

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        xm[i][j] = rnd_op();
        ym[i][j] = rnd_op();
      end
    @(negedge clk);
    bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rs_busy", 64'(bus.busy), 64'd1);
      set_lanes(k);
      @(negedge clk);
    end
    chk("rs_busy", 64'(bus.busy), 64'd1);
    xm = '{'{1, 1}, '{1, 1}};
    ym = '{'{1, 1}, '{1, 1}};
    do_run();
    chk("rs_pe00", 64'(bus.result_flat[0 +: AW]), 64'd2);
    check_results("restart");

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        xm[i][j] = rnd_op();
        ym[i][j] = rnd_op();
      end
    @(negedge clk);
    bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_lanes(k);
      @(negedge clk);
    end
    rst = 1'b1;
    rand_lanes();
    @(negedge clk);
    rst = 1'b0;
    zero_lanes();
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_flat", 64'(bus.result_flat), 64'd0);
    for (int c = 0; c < CC + 2; c++) @(negedge clk);
    chk("mrst_valid", 64'(bus.result_valid), 64'd0);
    chk("mrst_busy2", 64'(bus.busy), 64'd0);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          xm[i][j] = rnd_op();
          ym[i][j] = rnd_op();
        end
      do_run();
      check_results("rand");
      read_sweep();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
